mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: max cycles spent waiting for memRdy in one memory state before a bus error.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port op  in  6  opcode of the instruction register.
REQ-005 SHALL have port funct  in  6  function field of the instruction register.
REQ-006 SHALL have port zero  in  1  ALU zero flag.
REQ-007 SHALL have port memRdy  in  1  shared memory completes the current access this cycle.
REQ-008 SHALL have port pcWr  out  1  PC loads npc this cycle.
REQ-009 SHALL have port npcSel  out  3  000 pc+4, 001 beq, 010 j/jal, 100 jr.
REQ-010 SHALL have port irWr  out  1  instruction register loads memory data.
REQ-011 SHALL have ports memRd, memWr, iorD  out  1 each  read strobe, write strobe, address select (0 = PC, 1 = ALU result).
REQ-012 SHALL have ports regWr  out  1; regDst  out  2 (0 rt, 1 rd, 2 r31); memToReg  out  2 (0 ALU, 1 memory, 2 pcp4).
REQ-013 SHALL have ports aluSrc  out  1 (1 = immediate); aluOp  out  2 (0 add, 1 sub, 2 funct, 3 or); extOp  out  2 (0 zero-ext, 1 sign-ext, 2 lui).
REQ-014 SHALL have ports state  out  3 (current state); illegal  out  1; busErr  out  1.

Function
REQ-015 SHALL implement states FETCH=0, DCD=1, EXE=2, MEM=3, WB=4, HALT=5. Outputs are decoded from the registered state and op/funct/zero only.
REQ-016 FETCH: memRd=1, iorD=0; on memRdy: irWr=1, next DCD; else remain.
REQ-017 DCD: j gives pcWr=1, npcSel=010, next FETCH. jal does the same plus regWr=1, regDst=2, memToReg=2. jr (R, funct 001000) gives pcWr=1, npcSel=100, next FETCH.
REQ-018 DCD: addu/subu/ori/lui/lw/sw/beq go to EXE. Any other op/funct goes to HALT with illegal=1.
REQ-019 EXE: R-type gives aluOp=2, aluSrc=0. ori gives aluOp=3, aluSrc=1, extOp=0. lui gives extOp=2, aluSrc=1. lw/sw give aluOp=0, aluSrc=1, extOp=1. beq gives aluOp=1, pcWr=1, npcSel=001, next FETCH.
REQ-020 EXE next state: lw/sw go to MEM; the rest go to WB.
REQ-021 MEM lw: memRd=1, iorD=1; on memRdy, next WB.
REQ-022 MEM sw: memWr=1, iorD=1; on memRdy: pcWr=1, npcSel=000, next FETCH.
REQ-023 WB: regWr=1, pcWr=1, npcSel=000, next FETCH. regDst=1/memToReg=0 for R-type, regDst=0/memToReg=0 for ori/lui, regDst=0/memToReg=1 for lw.
REQ-024 SHALL assert pcWr exactly once per retired instruction and never in FETCH or HALT.
REQ-025 CPI with memRdy=1 on first cycle: j/jal/jr 2, beq 3, sw 4, R/ori/lui 4, lw 5. Each wait cycle adds 1.
REQ-026 Wait counter: 4 bits min, sized for WAIT_MAX. Cleared on entry to FETCH or MEM and on memRdy. Increments each cycle in FETCH/MEM without memRdy.
REQ-027 Counter reaching WAIT_MAX without memRdy: next HALT with busErr=1. memRdy on the same cycle the counter reaches WAIT_MAX wins, and the access completes normally.
REQ-028 HALT is sticky until rst. In HALT all strobes are 0 and illegal/busErr hold their values.
REQ-029 memRdy outside FETCH/MEM SHALL be ignored.

Reset
REQ-030 rst high at a clock edge: state=FETCH, counter=0, illegal=0, busErr=0.
REQ-031 While rst is high, pcWr, irWr, regWr, memRd and memWr SHALL be forced 0. The first memRd=1 occurs the cycle after rst deasserts.
REQ-032 rst during any wait, including mid-MEM, abandons the access with no pcWr/regWr issued.

Structure
REQ-033 Package mc_pkg SHALL hold state encodings, opcode/funct constants (R 000000, addu 100001, subu 100011, jr 001000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011) and npcSel codes.
REQ-034 Sub-module mc_decode SHALL be purely combinational, mapping op/funct to an instruction class and a legal flag.

Verification
REQ-035 addu with memRdy always 1: states 0,1,2,4,0. pcWr only in WB with npcSel=000. regWr=1, regDst=1 in WB.
REQ-036 lw with memRdy low 3 cycles in MEM: MEM occupies 4 cycles, then WB with memToReg=1. Total 8 cycles.
REQ-037 beq with zero=0 and with zero=1: EXE has pcWr=1, npcSel=001 in both cases. 3 cycles each.
REQ-038 jal: DCD has pcWr=1, npcSel=010, regWr=1, regDst=2, memToReg=2. Next state FETCH.
REQ-039 op=111111: HALT with illegal=1, which holds for 20 cycles. rst returns state to FETCH with illegal=0.
REQ-040 memRdy held 0 in FETCH: busErr=1 and state=5 after 15 wait cycles. A variant with memRdy=1 on the 15th cycle completes the fetch.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: state codes, opcode/funct
// fields, next-PC selects, datapath control codes and instruction classes.
package mc_pkg;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DCD   = 3'd1;
  localparam logic [2:0] S_EXE   = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [2:0] NPC_PC4 = 3'b000;
  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_FN  = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_MEM  = 2'd1;
  localparam logic [1:0] M2R_PCP4 = 2'd2;

  typedef enum logic [3:0] {
    CLS_RALU,
    CLS_JR,
    CLS_ORI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_ILL
  } instr_cls_t;

endpackage

// File: rtl/mc_if.sv
// Bus between the controller and the datapath/memory: instruction fields and
// status in, control strobes and status flags out.
interface mc_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memRdy;
  logic       pcWr;
  logic [2:0] npcSel;
  logic       irWr;
  logic       memRd;
  logic       memWr;
  logic       iorD;
  logic       regWr;
  logic [1:0] regDst;
  logic [1:0] memToReg;
  logic       aluSrc;
  logic [1:0] aluOp;
  logic [1:0] extOp;
  logic [2:0] state;
  logic       illegal;
  logic       busErr;

  modport master (
    input  op, funct, zero, memRdy,
    output pcWr, npcSel, irWr, memRd, memWr, iorD, regWr, regDst, memToReg,
           aluSrc, aluOp, extOp, state, illegal, busErr
  );

  modport slave (
    output op, funct, zero, memRdy,
    input  pcWr, npcSel, irWr, memRd, memWr, iorD, regWr, regDst, memToReg,
           aluSrc, aluOp, extOp, state, illegal, busErr
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to class plus legal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output instr_cls_t o_cls,
  output logic       o_legal
);

  always_comb begin
    o_cls = CLS_ILL;
    case (i_op)
      OP_R: begin
        case (i_funct)
          FN_ADDU, FN_SUBU: o_cls = CLS_RALU;
          FN_JR:            o_cls = CLS_JR;
          default:          o_cls = CLS_ILL;
        endcase
      end
      OP_ORI:  o_cls = CLS_ORI;
      OP_LUI:  o_cls = CLS_LUI;
      OP_LW:   o_cls = CLS_LW;
      OP_SW:   o_cls = CLS_SW;
      OP_BEQ:  o_cls = CLS_BEQ;
      OP_J:    o_cls = CLS_J;
      OP_JAL:  o_cls = CLS_JAL;
      default: o_cls = CLS_ILL;
    endcase
    o_legal = (o_cls != CLS_ILL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU controller: FETCH/DCD/EXE/MEM/WB sequencing with a bounded
// memory wait, sticky HALT on illegal instruction or bus timeout.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  mc_if.master bus
);

  localparam int unsigned CW = ($clog2(WAIT_MAX + 1) > 4) ? $clog2(WAIT_MAX + 1) : 4;

  logic [2:0]    r_state;
  logic [2:0]    w_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_illegal;
  logic          r_busErr;
  logic          w_set_ill;
  logic          w_set_bus;
  logic          w_mem_phase;
  logic          w_waiting;
  logic          w_wait_exp;
  logic          w_legal;
  instr_cls_t    w_cls;

  mc_decode u_decode (
    .i_op    (bus.op),
    .i_funct (bus.funct),
    .o_cls   (w_cls),
    .o_legal (w_legal)
  );

  // Timeout fires on the cycle that would bring the counter to WAIT_MAX, so a
  // memRdy arriving in that same cycle still completes the access.
  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_waiting   = w_mem_phase && !bus.memRdy;
  assign w_wait_exp  = w_waiting && (r_cnt == CW'(WAIT_MAX - 1));
  assign w_cnt_nxt   = w_waiting ? r_cnt + CW'(1) : '0;

  always_comb begin
    bus.pcWr     = 1'b0;
    bus.npcSel   = NPC_PC4;
    bus.irWr     = 1'b0;
    bus.memRd    = 1'b0;
    bus.memWr    = 1'b0;
    bus.iorD     = 1'b0;
    bus.regWr    = 1'b0;
    bus.regDst   = DST_RT;
    bus.memToReg = M2R_ALU;
    bus.aluSrc   = 1'b0;
    bus.aluOp    = ALU_ADD;
    bus.extOp    = EXT_ZERO;
    w_nxt        = r_state;
    w_set_ill    = 1'b0;
    w_set_bus    = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.memRd = 1'b1;
        if (bus.memRdy) begin
          bus.irWr = 1'b1;
          w_nxt    = S_DCD;
        end else if (w_wait_exp) begin
          w_nxt     = S_HALT;
          w_set_bus = 1'b1;
        end
      end
      S_DCD: begin
        if (!w_legal) begin
          w_nxt     = S_HALT;
          w_set_ill = 1'b1;
        end else begin
          case (w_cls)
            CLS_J, CLS_JAL: begin
              bus.pcWr   = 1'b1;
              bus.npcSel = NPC_J;
              w_nxt      = S_FETCH;
              if (w_cls == CLS_JAL) begin
                bus.regWr    = 1'b1;
                bus.regDst   = DST_R31;
                bus.memToReg = M2R_PCP4;
              end
            end
            CLS_JR: begin
              bus.pcWr   = 1'b1;
              bus.npcSel = NPC_JR;
              w_nxt      = S_FETCH;
            end
            default: w_nxt = S_EXE;
          endcase
        end
      end
      S_EXE: begin
        w_nxt = S_WB;
        case (w_cls)
          CLS_RALU: bus.aluOp = ALU_FN;
          CLS_ORI: begin
            bus.aluOp  = ALU_OR;
            bus.aluSrc = 1'b1;
          end
          CLS_LUI: begin
            bus.extOp  = EXT_LUI;
            bus.aluSrc = 1'b1;
          end
          CLS_LW, CLS_SW: begin
            bus.aluSrc = 1'b1;
            bus.extOp  = EXT_SIGN;
            w_nxt      = S_MEM;
          end
          CLS_BEQ: begin
            bus.aluOp  = ALU_SUB;
            bus.extOp  = EXT_SIGN;
            bus.pcWr   = 1'b1;
            bus.npcSel = NPC_BEQ;
            w_nxt      = S_FETCH;
          end
          default: begin
            w_nxt     = S_HALT;
            w_set_ill = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        bus.iorD   = 1'b1;
        bus.aluSrc = 1'b1;
        bus.extOp  = EXT_SIGN;
        if (w_cls == CLS_SW) bus.memWr = 1'b1;
        else                 bus.memRd = 1'b1;
        if (bus.memRdy) begin
          if (w_cls == CLS_SW) begin
            bus.pcWr = 1'b1;
            w_nxt    = S_FETCH;
          end else begin
            w_nxt = S_WB;
          end
        end else if (w_wait_exp) begin
          w_nxt     = S_HALT;
          w_set_bus = 1'b1;
        end
      end
      S_WB: begin
        bus.regWr = 1'b1;
        bus.pcWr  = 1'b1;
        w_nxt     = S_FETCH;
        if (w_cls == CLS_RALU) bus.regDst = DST_RD;
        if (w_cls == CLS_LW)   bus.memToReg = M2R_MEM;
      end
      S_HALT:  w_nxt = S_HALT;
      default: w_nxt = S_FETCH;
    endcase
    if (rst) begin
      bus.pcWr  = 1'b0;
      bus.irWr  = 1'b0;
      bus.regWr = 1'b0;
      bus.memRd = 1'b0;
      bus.memWr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_bus) r_busErr  <= 1'b1;
    end
  end

  assign bus.state   = r_state;
  assign bus.illegal = r_illegal;
  assign bus.busErr  = r_busErr;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle traces built from the
// phase rules (fetch, decode, execute, memory, writeback) and CPI targets.
module tb_mc_ctrl;

  localparam int unsigned WAIT_MAX  = 15;
  localparam int unsigned HALT_HOLD = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mc_if bus();

  mc_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL} kind_t;

  typedef struct {
    logic       memRdy;
    logic [2:0] st;
    logic       pcWr;
    logic [2:0] npc;
    logic       irWr, memRd, memWr, iorD, regWr;
    logic [1:0] regDst, m2r;
    logic [4:0] alu;    // {aluSrc, aluOp, extOp}
    logic [4:0] alu_m;  // which alu bits are defined for this cycle
    logic       ill, berr;
  } cyc_t;

  typedef struct {
    string       name;
    kind_t       k;
    logic        zero;
    int unsigned fw;
    int unsigned mw;
    int          cpi;
  } dir_t;

  cyc_t q[$];

  function automatic void enc(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom_range(0, 63));
    case (k)
      K_ADDU:  begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU:  begin op = 6'b000000; fn = 6'b100011; end
      K_JR:    begin op = 6'b000000; fn = 6'b001000; end
      K_ORI:   op = 6'b001101;
      K_LUI:   op = 6'b001111;
      K_LW:    op = 6'b100011;
      K_SW:    op = 6'b101011;
      K_BEQ:   op = 6'b000100;
      K_J:     op = 6'b000010;
      K_JAL:   op = 6'b000011;
      default: op = 6'b111111;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c = '{default: '0};
    c.st = st;
    c.memRdy = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Pushes the stalled cycles of one memory access; 0 means it timed out.
  function automatic bit add_wait(input cyc_t c, input int unsigned waits);
    int unsigned n;
    n = (waits >= WAIT_MAX) ? WAIT_MAX : waits;
    c.memRdy = 1'b0;
    for (int unsigned i = 0; i < n; i++) q.push_back(c);
    return waits < WAIT_MAX;
  endfunction

  function automatic void add_halt(input logic ill, input logic berr);
    cyc_t c;
    for (int unsigned i = 0; i < HALT_HOLD; i++) begin
      c = blank(3'd5);
      c.ill = ill;
      c.berr = berr;
      q.push_back(c);
    end
  endfunction

  function automatic void build(input kind_t k, input int unsigned fw, input int unsigned mw);
    cyc_t c;
    q.delete();
    c = blank(3'd0);
    c.memRd = 1'b1;
    if (!add_wait(c, fw)) begin add_halt(1'b0, 1'b1); return; end
    c.memRdy = 1'b1;
    c.irWr = 1'b1;
    q.push_back(c);
    c = blank(3'd1);
    if (k == K_J || k == K_JAL) begin c.pcWr = 1'b1; c.npc = 3'b010; end
    if (k == K_JAL) begin c.regWr = 1'b1; c.regDst = 2'd2; c.m2r = 2'd2; end
    if (k == K_JR) begin c.pcWr = 1'b1; c.npc = 3'b100; end
    q.push_back(c);
    if (k == K_ILL) begin add_halt(1'b1, 1'b0); return; end
    if (k == K_J || k == K_JAL || k == K_JR) return;
    c = blank(3'd2);
    case (k)
      K_ADDU, K_SUBU: begin c.alu = {1'b0, 2'd2, 2'd0}; c.alu_m = 5'b11100; end
      K_ORI:          begin c.alu = {1'b1, 2'd3, 2'd0}; c.alu_m = 5'b11111; end
      K_LUI:          begin c.alu = {1'b1, 2'd0, 2'd2}; c.alu_m = 5'b10011; end
      K_LW, K_SW:     begin c.alu = {1'b1, 2'd0, 2'd1}; c.alu_m = 5'b11111; end
      default:        begin c.alu = {1'b0, 2'd1, 2'd0}; c.alu_m = 5'b01100;
                            c.pcWr = 1'b1; c.npc = 3'b001; end
    endcase
    q.push_back(c);
    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      c = blank(3'd3);
      c.iorD = 1'b1;
      if (k == K_SW) c.memWr = 1'b1;
      else           c.memRd = 1'b1;
      if (!add_wait(c, mw)) begin add_halt(1'b0, 1'b1); return; end
      c.memRdy = 1'b1;
      if (k == K_SW) begin c.pcWr = 1'b1; c.npc = 3'b000; q.push_back(c); return; end
      q.push_back(c);
    end
    c = blank(3'd4);
    c.regWr = 1'b1;
    c.pcWr = 1'b1;
    c.regDst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    c.m2r = (k == K_LW) ? 2'd1 : 2'd0;
    q.push_back(c);
  endfunction

  // Cycles per instruction from the retirement rules; 0 when it never retires.
  function automatic int cpi_of(input kind_t k, input int unsigned fw, input int unsigned mw);
    if (fw >= WAIT_MAX || k == K_ILL) return 0;
    case (k)
      K_J, K_JAL, K_JR: return 2 + int'(fw);
      K_BEQ:            return 3 + int'(fw);
      K_LW:             return (mw >= WAIT_MAX) ? 0 : 5 + int'(fw) + int'(mw);
      K_SW:             return (mw >= WAIT_MAX) ? 0 : 4 + int'(fw) + int'(mw);
      default:          return 4 + int'(fw);
    endcase
  endfunction

  function automatic cyc_t sample();
    cyc_t a;
    a = '{default: '0};
    a.st = bus.state;     a.pcWr = bus.pcWr;   a.npc = bus.npcSel;
    a.irWr = bus.irWr;    a.memRd = bus.memRd; a.memWr = bus.memWr;
    a.iorD = bus.iorD;    a.regWr = bus.regWr; a.regDst = bus.regDst;
    a.m2r = bus.memToReg; a.alu = {bus.aluSrc, bus.aluOp, bus.extOp};
    a.ill = bus.illegal;  a.berr = bus.busErr;
    return a;
  endfunction

  function automatic string fmt(input cyc_t c);
    return $sformatf("st=%0d pcWr=%b npc=%b irWr=%b rd=%b wr=%b iorD=%b regWr=%b dst=%0d m2r=%0d alu=%b ill=%b berr=%b",
                     c.st, c.pcWr, c.npc, c.irWr, c.memRd, c.memWr, c.iorD, c.regWr,
                     c.regDst, c.m2r, c.alu, c.ill, c.berr);
  endfunction

  task automatic check_cyc(input cyc_t e, input cyc_t a, input string nm);
    bit ok;
    ok = (a.st === e.st) && (a.pcWr === e.pcWr) && (a.irWr === e.irWr) &&
         (a.memRd === e.memRd) && (a.memWr === e.memWr) && (a.regWr === e.regWr) &&
         (a.ill === e.ill) && (a.berr === e.berr) &&
         (((a.alu ^ e.alu) & e.alu_m) === 5'b0);
    if (e.pcWr) ok = ok && (a.npc === e.npc);
    if (e.memRd || e.memWr) ok = ok && (a.iorD === e.iorD);
    if (e.regWr) ok = ok && (a.regDst === e.regDst) && (a.m2r === e.m2r);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s got {%s} want {%s} (alu mask %b)", nm, fmt(a), fmt(e), e.alu_m);
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_trace(input string tag, input int unsigned nmax, input int exp_cpi, input bit chk_cpi);
    cyc_t a;
    int   meas;
    meas = 0;
    for (int unsigned i = 0; i < q.size() && i < nmax; i++) begin
      bus.memRdy = q[i].memRdy;
      @(negedge clk);
      a = sample();
      check_cyc(q[i], a, $sformatf("%s#%0d", tag, i));
      if (a.pcWr === 1'b1 && meas == 0) meas = int'(i) + 1;
      @(posedge clk);
      #1;
    end
    if (chk_cpi) cmp({tag, "_cpi"}, meas, exp_cpi);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.memRdy = 1'b1;
    @(negedge clk);
    cmp("rst_strobe", {bus.pcWr, bus.irWr, bus.regWr, bus.memRd, bus.memWr}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp("rst_state", {bus.state, bus.illegal, bus.busErr,
                      bus.pcWr, bus.irWr, bus.regWr, bus.memRd, bus.memWr}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_instr(input string tag, input kind_t k, input logic z,
                           input int unsigned fw, input int unsigned mw, input int exp_cpi);
    logic [5:0] op, fn;
    enc(k, op, fn);
    bus.op = op;
    bus.funct = fn;
    bus.zero = z;
    build(k, fw, mw);
    run_trace(tag, q.size(), exp_cpi, 1'b1);
    if (cpi_of(k, fw, mw) == 0) do_reset();
  endtask

  dir_t tbl[16];

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    kind_t       k;
    int unsigned fw, mw;
    logic [5:0]  op, fn;

    tbl[0]  = '{"addu",   K_ADDU, 1'b0, 0,  0,  4};
    tbl[1]  = '{"lw_w3",  K_LW,   1'b0, 0,  3,  8};
    tbl[2]  = '{"beq_z0", K_BEQ,  1'b0, 0,  0,  3};
    tbl[3]  = '{"beq_z1", K_BEQ,  1'b1, 0,  0,  3};
    tbl[4]  = '{"jal",    K_JAL,  1'b0, 0,  0,  2};
    tbl[5]  = '{"j_f1",   K_J,    1'b0, 1,  0,  3};
    tbl[6]  = '{"jr",     K_JR,   1'b0, 0,  0,  2};
    tbl[7]  = '{"sw_w2",  K_SW,   1'b0, 0,  2,  6};
    tbl[8]  = '{"ori_f2", K_ORI,  1'b0, 2,  0,  6};
    tbl[9]  = '{"lui",    K_LUI,  1'b0, 0,  0,  4};
    tbl[10] = '{"subu",   K_SUBU, 1'b1, 0,  1,  4};
    tbl[11] = '{"f14",    K_ADDU, 1'b0, 14, 0,  18};
    tbl[12] = '{"lw_m14", K_LW,   1'b0, 0,  14, 19};
    tbl[13] = '{"ill",    K_ILL,  1'b0, 0,  0,  0};
    tbl[14] = '{"f_to",   K_ADDU, 1'b0, 15, 0,  0};
    tbl[15] = '{"sw_to",  K_SW,   1'b0, 0,  15, 0};

    bus.op = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.memRdy = 1'b0;
    do_reset();

    foreach (tbl[i])
      run_instr(tbl[i].name, tbl[i].k, tbl[i].zero, tbl[i].fw, tbl[i].mw, tbl[i].cpi);

    // Reset in the middle of a stalled load: the access is dropped silently.
    enc(K_LW, op, fn);
    bus.op = op;
    bus.funct = fn;
    build(K_LW, 0, 5);
    run_trace("lw_rst", 5, 0, 1'b0);
    do_reset();
    run_instr("after_rst", K_ADDU, 1'b0, 0, 0, 4);

    for (int i = 0; i < 60; i++) begin
      k  = kind_t'($urandom_range(0, 9));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run_instr($sformatf("rnd%0d", i), k, 1'($urandom_range(0, 1)), fw, mw, cpi_of(k, fw, mw));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
